multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: a ten-state instruction FSM, condition
// evaluation against the architectural flags, and the flag register itself.
// Write enables are gated by the condition check and forced low in reset.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;

  // Kept as a plain vector so unused codes 10-15 are representable.
  logic [3:0] state_reg;
  state_t     state_next;
  logic [3:0] flags_reg;
  logic [3:0] flags_next;

  logic [3:0] cmd;
  logic [3:0] cmd_alu;
  logic       cmd_ok;
  logic       cmd_arith;
  logic       cmd_cmp;
  logic       cond_ex;
  logic       nextpc;
  logic       branch;
  logic       regw;
  logic       memw;
  logic       irw;
  logic       exec_st;
  logic       pcs;

  assign cmd = Funct[4:1];

  // Data-processing command decode: ALU operation, support and C/V ownership.
  always_comb begin
    cmd_alu   = ALU_ADD;
    cmd_ok    = 1'b0;
    cmd_arith = 1'b0;
    case (cmd)
      4'b0100: begin cmd_alu = ALU_ADD; cmd_ok = 1'b1; cmd_arith = 1'b1; end
      4'b0010: begin cmd_alu = ALU_SUB; cmd_ok = 1'b1; cmd_arith = 1'b1; end
      4'b0000: begin cmd_alu = ALU_AND; cmd_ok = 1'b1; end
      4'b1100: begin cmd_alu = ALU_ORR; cmd_ok = 1'b1; end
      4'b1010: begin cmd_alu = ALU_SUB; cmd_ok = 1'b1; cmd_arith = 1'b1; end
      default: begin cmd_alu = ALU_ADD; end
    endcase
  end

  assign cmd_cmp = (cmd == 4'b1010);

  // Condition check always uses the registered (pre-update) flags.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flags_reg[2];
      4'b0001: cond_ex = ~flags_reg[2];
      4'b0010: cond_ex = flags_reg[1];
      4'b0011: cond_ex = ~flags_reg[1];
      4'b0100: cond_ex = flags_reg[3];
      4'b0101: cond_ex = ~flags_reg[3];
      4'b0110: cond_ex = flags_reg[0];
      4'b0111: cond_ex = ~flags_reg[0];
      4'b1000: cond_ex = flags_reg[1] & ~flags_reg[2];
      4'b1001: cond_ex = ~flags_reg[1] | flags_reg[2];
      4'b1010: cond_ex = (flags_reg[3] == flags_reg[0]);
      4'b1011: cond_ex = (flags_reg[3] != flags_reg[0]);
      4'b1100: cond_ex = ~flags_reg[2] & (flags_reg[3] == flags_reg[0]);
      4'b1101: cond_ex = flags_reg[2] | (flags_reg[3] != flags_reg[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // State register; reset returns to FETCH so the first edge fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

  // Next state and Moore control outputs.
  always_comb begin
    state_next = FETCH;
    nextpc     = 1'b0;
    branch     = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    irw        = 1'b0;
    exec_st    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (state_reg)
      FETCH: begin
        irw        = 1'b1;
        nextpc     = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_next = Funct[5] ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        regw       = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        memw       = 1'b1;
        state_next = FETCH;
      end
      EXECR: begin
        exec_st    = 1'b1;
        ALUControl = cmd_alu;
        state_next = ALUWB;
      end
      EXECI: begin
        exec_st    = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = cmd_alu;
        state_next = ALUWB;
      end
      ALUWB: begin
        ALUControl = cmd_alu;
        regw       = cmd_ok & ~cmd_cmp;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Flag update at the end of an execute state; C,V only for arithmetic.
  always_comb begin
    flags_next = flags_reg;
    if (exec_st && Funct[0] && cond_ex && cmd_ok) begin
      flags_next[3:2] = ALUFlags[3:2];
      if (cmd_arith) flags_next[1:0] = ALUFlags[1:0];
    end
  end

  // Architectural flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_reg <= 4'b0000;
    else        flags_reg <= flags_next;
  end

  assign pcs      = branch | (regw & (Rd == 4'd15));
  assign PCWrite  = reset & (nextpc | (pcs & cond_ex));
  assign RegWrite = reset & regw & cond_ex;
  assign MemWrite = reset & memw & cond_ex;
  assign IRWrite  = reset & irw;
  assign Flags    = flags_reg;
  assign State    = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized and directed checks of multicycle_ctrl against an instruction-level
// model: each instruction class expands to its expected state walk, and the
// per-state enables, mux selects and flags are derived from the ISA rules.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] Cond = 4'd14;
  logic [1:0] Op = 2'd0;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic [3:0] ALUFlags = 4'd0;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB;
  logic [3:0] ALUControl, Flags, State;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags = 4'd0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .Flags(Flags), .State(State)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ALU code for a data-processing cmd, or -1 if the cmd is unsupported.
  function automatic int alu_of(input logic [3:0] c);
    case (c)
      4'b0100: return 0;
      4'b0010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      4'b1010: return 1;
      default: return -1;
    endcase
  endfunction

  // Checks taken while reset is held low.
  task automatic check_reset(input string tag);
    check({tag, ".state"}, 32'(State), 32'd0);
    check({tag, ".flags"}, 32'(Flags), 32'd0);
    check({tag, ".wen"}, 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
    check({tag, ".mux"}, 32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}),
          32'(10'b0_10_1_10_0000));
  endtask

  // Runs one instruction from FETCH. Entered and left in the clock-low phase.
  task automatic run_instr(input int n, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd,
                           input logic [3:0] af, input bit rnd_af,
                           input int abort_at, input int force_at);
    int seq[$];
    int st, a;
    bit ce, sup, regw_dp, ep, er, em, ei;
    logic [3:0] cmd, ctl;
    logic [9:0] mv, mm;
    string t;
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      2'b00: begin seq.push_back(fn[5] ? 7 : 6); seq.push_back(8); end
      2'b01: begin
        seq.push_back(2);
        if (fn[0]) begin seq.push_back(3); seq.push_back(4); end
        else seq.push_back(5);
      end
      2'b10: seq.push_back(9);
      default: ;
    endcase
    cmd = fn[4:1];
    a = alu_of(cmd);
    sup = (a >= 0);
    regw_dp = sup && (cmd != 4'b1010);
    ctl = sup ? 4'(a) : 4'd0;
    Cond = c; Op = op; Funct = fn; Rd = rd;
    $display("instr %0d cond=%0d op=%0d funct=%b rd=%0d cycles=%0d flags=%b",
             n, c, op, fn, rd, seq.size(), mflags);
    for (int k = 0; k < seq.size(); k++) begin
      st = seq[k];
      ALUFlags = rnd_af ? 4'($urandom) : af;
      #1;
      ce = cond_holds(c, mflags);
      ep = 0; er = 0; em = 0; ei = 0; mv = '0; mm = '0;
      case (st)
        0: begin ep = 1; ei = 1; mv = 10'b0_10_1_10_0000; mm = 10'b1_11_1_11_1111; end
        1: begin mv = 10'b0_10_1_10_0000; mm = 10'b0_11_1_11_1111; end
        2: begin mv = 10'b0_00_0_01_0000; mm = 10'b0_00_1_11_1111; end
        3: begin mv = 10'b1_00_0_00_0000; mm = 10'b1_00_0_00_0000; end
        4: begin er = ce; ep = ce && (rd == 4'd15);
                 mv = 10'b0_01_0_00_0000; mm = 10'b0_11_0_00_0000; end
        5: begin em = ce; mv = 10'b1_00_0_00_0000; mm = 10'b1_00_0_00_0000; end
        6: begin mv = {6'b0_00_0_00, ctl}; mm = 10'b0_00_1_11_1111; end
        7: begin mv = {6'b0_00_0_01, ctl}; mm = 10'b0_00_1_11_1111; end
        8: begin er = ce && regw_dp; ep = er && (rd == 4'd15);
                 mv = {6'b0_00_0_00, ctl}; mm = 10'b0_11_0_00_1111; end
        default: begin ep = ce; mv = 10'b0_10_0_01_0000; mm = 10'b0_11_1_11_1111; end
      endcase
      t = $sformatf("i%0d.c%0d", n, k);
      check({t, ".state"}, 32'(State), 32'(st));
      check({t, ".flags"}, 32'(Flags), 32'(mflags));
      check({t, ".pcwrite"}, 32'(PCWrite), 32'(ep));
      check({t, ".regwrite"}, 32'(RegWrite), 32'(er));
      check({t, ".memwrite"}, 32'(MemWrite), 32'(em));
      check({t, ".irwrite"}, 32'(IRWrite), 32'(ei));
      check({t, ".mux"}, 32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl} & mm),
            32'(mv));
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        check_reset({t, ".abort"});
        mflags = 4'd0;
        reset = 1'b1;
        return;
      end
      if (k == force_at) begin
        force dut.state_reg = 4'd12;
        #1;
        check({t, ".forced_state"}, 32'(State), 32'd12);
        check({t, ".forced_wen"}, 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
        release dut.state_reg;
      end
      @(posedge clk);
      if ((st == 6 || st == 7) && fn[0] && ce && sup) begin
        mflags[3:2] = ALUFlags[3:2];
        if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)
          mflags[1:0] = ALUFlags[1:0];
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] cmds [5];
    logic [3:0] rc, rcmd, rrd;
    logic [5:0] rfn;
    logic [1:0] rop;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010;

    repeat (2) @(negedge clk);
    #1;
    check_reset("reset");
    @(posedge clk);
    @(negedge clk);
    #1;
    check_reset("reset_held");
    reset = 1'b1;

    // Load, then SUBS, CMP, BEQ taken/not taken, ADD to PC, store NE, no-op.
    run_instr(1, 4'b1110, 2'b01, 6'b011001, 4'd3, 4'd0, 0, -1, -1);
    run_instr(2, 4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0110, 0, -1, -1);
    run_instr(3, 4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0100, 0, -1, -1);
    run_instr(4, 4'b0000, 2'b10, 6'b000000, 4'd0, 4'd0, 0, -1, -1);
    run_instr(5, 4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0000, 0, -1, -1);
    run_instr(6, 4'b0000, 2'b10, 6'b000000, 4'd0, 4'd0, 0, -1, -1);
    run_instr(7, 4'b1110, 2'b00, 6'b001000, 4'd15, 4'd0, 0, -1, -1);
    run_instr(8, 4'b1111, 2'b00, 6'b001000, 4'd15, 4'd0, 0, -1, -1);
    run_instr(9, 4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0100, 0, -1, -1);
    run_instr(10, 4'b0001, 2'b01, 6'b011000, 4'd4, 4'd0, 0, -1, -1);
    run_instr(11, 4'b1110, 2'b11, 6'b000000, 4'd15, 4'd0, 0, -1, -1);
    // Flags nonzero before the abort so the reset clearing them is visible.
    run_instr(12, 4'b1110, 2'b00, 6'b000101, 4'd1, 4'b1111, 0, -1, -1);
    run_instr(13, 4'b1110, 2'b01, 6'b011001, 4'd5, 4'd0, 0, 3, -1);
    run_instr(14, 4'b1110, 2'b00, 6'b001001, 4'd6, 4'b1001, 0, -1, -1);
    run_instr(15, 4'b1110, 2'b11, 6'b000000, 4'd0, 4'd0, 0, -1, 1);
    run_instr(16, 4'b1110, 2'b00, 6'b111111, 4'd15, 4'b1111, 0, -1, -1);

    for (int i = 0; i < 300; i++) begin
      rc   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1110;
      rop  = 2'($urandom);
      rcmd = ($urandom_range(0, 4) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 4)];
      rfn  = {1'($urandom), rcmd, 1'($urandom)};
      rrd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr(100 + i, rc, rop, rfn, rrd, 4'd0, 1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
